// File: rtl/dualmem_port_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dualmem_port_ctrl
//  Purpose  : Valid/ready request front-end for one port of the dual-port
//             scratchpad. Converts byte-addressed requests into word-level
//             port signals, absorbs the 1-cycle read latency into an in-order
//             response FIFO, and optionally zero-fills the array after reset.
//  Revision : 1.0 - initial release
// ============================================================================
module dualmem_port_ctrl #(
  parameter int ADDR_W    = 13,
  parameter int DATA_W    = 64,
  parameter int RSP_DEPTH = 3,
  parameter int INIT_ZERO = 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [DATA_W/8-1:0] req_be,
  input  logic [ADDR_W+2:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_we,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                init_done,
  output logic [DATA_W/8-1:0] mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int c_PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int c_CNT_W = $clog2(RSP_DEPTH + 1);
  localparam logic [c_CNT_W:0]  c_DEPTH    = (c_CNT_W + 1)'(RSP_DEPTH);
  localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(RSP_DEPTH - 1);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam state_t c_RST_STATE = (INIT_ZERO != 0) ? ST_INIT : ST_RUN;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_armed;       // keeps the fill writes off while rstn is low
  logic [ADDR_W-1:0]   r_cnt;
  logic                r_init_done;
  logic                r_inflight;
  logic                r_infl_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [DATA_W-1:0]   r_fifo_data [RSP_DEPTH];
  logic                r_fifo_we   [RSP_DEPTH];
  logic [c_PTR_W-1:0]  r_wptr;
  logic [c_PTR_W-1:0]  r_rptr;
  logic [c_CNT_W-1:0]  r_fifo_cnt;

  logic                w_fill;
  logic                w_accept;
  logic                w_push;
  logic                w_pop;
  logic [c_CNT_W:0]    w_used;
  logic [DATA_W-1:0]   w_push_data;
  logic                w_unused_addr_lsbs;

  assign w_unused_addr_lsbs = ^req_addr[2:0];

  // Credits count both queued responses and the read still in the memory pipe.
  assign w_used    = {1'b0, r_fifo_cnt} + {{c_CNT_W{1'b0}}, r_inflight};
  assign req_ready = r_init_done && (r_state == ST_RUN) && (w_used < c_DEPTH);
  assign w_accept  = req_valid && req_ready;
  assign w_fill    = (r_state == ST_INIT) && r_armed;

  assign w_push      = r_inflight;
  assign w_push_data = r_infl_we ? '0 : mem_rdata;
  assign rsp_valid   = (r_fifo_cnt != '0);
  assign w_pop       = rsp_valid && rsp_ready;
  assign rsp_rdata   = rsp_valid ? r_fifo_data[r_rptr] : '0;
  assign rsp_we      = rsp_valid && r_fifo_we[r_rptr];
  assign init_done   = r_init_done;

  // Next-state and memory-port drive: fill writes, accepted requests, or idle hold.
  always_comb begin
    w_state_nxt = r_state;
    mem_en      = '0;
    mem_we      = '0;
    mem_addr    = r_mem_addr;
    mem_wdata   = r_mem_wdata;
    if (w_fill) begin
      mem_en    = '1;
      mem_we    = '1;
      mem_addr  = r_cnt;
      mem_wdata = '0;
      if (r_cnt == '1) begin
        w_state_nxt = ST_RUN;
      end
    end else if (w_accept) begin
      mem_en    = '1;
      mem_we    = req_we ? req_be : '0;
      mem_addr  = req_addr[ADDR_W+2:3];
      mem_wdata = req_wdata;
    end
  end

  // State register, fill counter, in-flight tracking and response FIFO.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= c_RST_STATE;
      r_armed     <= 1'b0;
      r_cnt       <= '0;
      r_init_done <= 1'b0;
      r_inflight  <= 1'b0;
      r_infl_we   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_fifo_cnt  <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_we[i]   <= 1'b0;
      end
    end else begin
      r_state     <= w_state_nxt;
      r_armed     <= 1'b1;
      r_mem_addr  <= mem_addr;
      r_mem_wdata <= mem_wdata;
      if (w_fill) begin
        r_cnt <= r_cnt + ADDR_W'(1);
      end
      if (w_state_nxt == ST_RUN) begin
        r_init_done <= 1'b1;
      end
      r_inflight <= w_accept;
      r_infl_we  <= w_accept && req_we;
      if (w_push) begin
        r_fifo_data[r_wptr] <= w_push_data;
        r_fifo_we[r_wptr]   <= r_infl_we;
        r_wptr <= (r_wptr == c_PTR_LAST) ? '0 : r_wptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == c_PTR_LAST) ? '0 : r_rptr + c_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + c_CNT_W'(1);
        2'b01:   r_fifo_cnt <= r_fifo_cnt - c_CNT_W'(1);
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

endmodule
`default_nettype wire
